// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bus of the data-memory stage.
// master: the EXE/MEM pipeline side issuing loads and stores.
// slave:  the SRAM controller serving them.
interface sram_controller_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output MEM_R_EN, MEM_W_EN, address, writeData,
    input  readData, ready
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, writeData,
    output readData, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Data-memory access stage: performs each 32-bit load/store as two 16-bit
// accesses (low half, then high half) on an external asynchronous SRAM and
// holds ready low while the access is in flight.
// Optional feature: define SRAM_LASTREAD_CACHE_EN to build a one-entry
// last-read cache that serves repeated loads of the same word with no stall.
module sram_controller #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WORD_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_write_q, is_write_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                we_n_d;
  logic                drive_q, drive_d;

  logic [31:0]         offset;
  logic [WORD_W-1:0]   req_word;
  logic                unused_offset_bits;
  logic                hit;
  logic [31:0]         hit_data;

  // Byte address to SRAM word index; byte lane bits and overflow are dropped
  assign offset             = bus.address - BASE_ADDR;
  assign req_word           = offset[ADDR_W:2];
  assign unused_offset_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // Store data goes out only while a store phase owns the bus
  assign SRAM_DQ = drive_q ? ((state_q == HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;

  assign bus.readData = rdata_q;
  assign bus.ready    = ((state_q == IDLE) && ((!bus.MEM_R_EN && !bus.MEM_W_EN) || hit))
                        || (state_q == DONE);

`ifdef SRAM_LASTREAD_CACHE_EN
  logic              cache_valid_q;
  logic [WORD_W-1:0] cache_tag_q;
  logic [31:0]       cache_data_q;

  assign hit      = (state_q == IDLE) && bus.MEM_R_EN && !bus.MEM_W_EN
                    && cache_valid_q && (cache_tag_q == req_word);
  assign hit_data = cache_data_q;

  // Fill on every completed read; drop the entry when its word is stored to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else if (state_q == DONE) begin
      if (!is_write_q) begin
        cache_valid_q <= 1'b1;
        cache_tag_q   <= word_q;
        cache_data_q  <= rdata_q;
      end else if (word_q == cache_tag_q) begin
        cache_valid_q <= 1'b0;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // Next state plus next values of the registered SRAM-side outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    addr_d     = SRAM_ADDR;
    we_n_d     = 1'b1;
    drive_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          rdata_d = hit_data;
        end else if (bus.MEM_R_EN || bus.MEM_W_EN) begin
          state_d    = LO;
          cnt_d      = '0;
          is_write_d = bus.MEM_W_EN;
          word_d     = req_word;
          wdata_d    = bus.writeData;
          addr_d     = {req_word, 1'b0};
          we_n_d     = !bus.MEM_W_EN || (CNT_LAST == '0);
          drive_d    = bus.MEM_W_EN;
        end
      end
      LO: begin
        drive_d = is_write_q;
        if (cnt_q == CNT_LAST) begin
          state_d = HI;
          cnt_d   = '0;
          addr_d  = {word_q, 1'b1};
          we_n_d  = !is_write_q || (CNT_LAST == '0);
          if (!is_write_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          we_n_d = !is_write_q || (cnt_d == CNT_LAST);
        end
      end
      HI: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!is_write_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          we_n_d  = !is_write_q || (cnt_d == CNT_LAST);
          drive_d = is_write_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, phase counter, latched request and registered SRAM outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      SRAM_ADDR  <= '0;
      SRAM_WE_N  <= 1'b1;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      SRAM_ADDR  <= addr_d;
      SRAM_WE_N  <= we_n_d;
      drive_q    <= drive_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: asynchronous SRAM model on the pins, a word-level
// reference memory plus last-read cache model, directed and random accesses.
`timescale 1ns/1ps
module tb_sram_controller;
  localparam int ADDR_W = 18;
  localparam int WAIT   = 2;
  localparam int LAT    = 2 * WAIT + 1;
  localparam int MEM_N  = 1024;
`ifdef SRAM_LASTREAD_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  wire  [15:0]       SRAM_DQ;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;

  sram_controller_if bus();

  sram_controller #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: drives read data while a load is outstanding
  logic [15:0] sram [MEM_N];
  logic        tb_reading;
  logic        probe_en;
  assign SRAM_DQ = probe_en ? 16'h0000
                 : ((tb_reading && SRAM_WE_N) ? sram[SRAM_ADDR[9:0]] : 16'hzzzz);

  always @(posedge clk) begin
    if (!SRAM_WE_N) sram[SRAM_ADDR[9:0]] = SRAM_DQ;
  end

  // Reference model
  logic [15:0] ref_mem [MEM_N];
  logic [31:0] rd_exp;
  bit          c_valid;
  logic [16:0] c_tag;
  logic [31:0] c_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // With no DUT driver the net equals the probe value of zero
  task automatic check_dq_released(input string tag);
    probe_en = 1'b1;
    #1;
    check(tag, 32'(SRAM_DQ), 32'h0);
    probe_en = 1'b0;
  endtask

  // One pipeline request, started at a negedge; returns one cycle after it retires
  task automatic do_access(input bit w, input bit r, input logic [31:0] addr, input logic [31:0] wd);
    logic [16:0] word;
    logic [9:0]  lo_i;
    bit          hit;
    int          exp_stall;
    int          k;
    int          cnt;
    bit          lo;
    logic [17:0] exp_addr;
    word      = 17'((addr - 32'd1024) >> 2);
    lo_i      = 10'({word, 1'b0});
    hit       = CACHE_ON && r && !w && c_valid && (c_tag == word);
    exp_stall = ((w || r) && !hit) ? LAT : 0;
    bus.MEM_W_EN  = w;
    bus.MEM_R_EN  = r;
    bus.address   = addr;
    bus.writeData = wd;
    tb_reading    = r && !w;
    #1;
    k = 0;
    while (bus.ready !== 1'b1 && k < 4 * LAT) begin
      if (k >= 1 && k <= 2 * WAIT) begin
        lo       = (k <= WAIT);
        cnt      = lo ? k - 1 : k - 1 - WAIT;
        exp_addr = {word, !lo};
        check("sram_addr", 32'(SRAM_ADDR), 32'(exp_addr));
        check("we_n", 32'(SRAM_WE_N), (w && cnt != WAIT - 1) ? 32'd0 : 32'd1);
        if (w) check("dq_write", 32'(SRAM_DQ), 32'(lo ? wd[15:0] : wd[31:16]));
      end
      @(negedge clk);
      k++;
    end
    check("stall", 32'(k), 32'(exp_stall));
    if (w) begin
      ref_mem[lo_i]      = wd[15:0];
      ref_mem[lo_i + 1]  = wd[31:16];
      if (c_valid && c_tag == word) c_valid = 1'b0;
    end else if (r) begin
      if (hit) begin
        rd_exp = c_data;
      end else begin
        rd_exp  = {ref_mem[lo_i + 1], ref_mem[lo_i]};
        c_valid = 1'b1;
        c_tag   = word;
        c_data  = rd_exp;
        check("rdata_done", bus.readData, rd_exp);
      end
    end
    @(negedge clk);
    check("rdata_hold", bus.readData, rd_exp);
  endtask

  logic [31:0] a, wd;
  int          op;
  logic [15:0] v;

  initial begin
    for (int i = 0; i < MEM_N; i++) begin
      v          = 16'($urandom);
      sram[i]    = v;
      ref_mem[i] = v;
    end
    rd_exp        = '0;
    c_valid       = 1'b0;
    c_tag         = '0;
    c_data        = '0;
    tb_reading    = 1'b0;
    probe_en      = 1'b0;
    bus.MEM_R_EN  = 1'b0;
    bus.MEM_W_EN  = 1'b0;
    bus.address   = '0;
    bus.writeData = '0;
    rst           = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst_rdata", bus.readData, 32'h0);
    check("rst_addr", 32'(SRAM_ADDR), 32'h0);
    check_dq_released("rst_dq");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.ready), 32'd1);
    check("idle_we_n", 32'(SRAM_WE_N), 32'd1);
    check("tied_pins", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}), 32'h0);
    check_dq_released("idle_dq");
    repeat (3) do_access(1'b0, 1'b0, 32'd1024, 32'h0);

    // Store, then load back
    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    check("sram_w0", 32'(sram[0]), 32'h0000BEEF);
    check("sram_w1", 32'(sram[1]), 32'h0000DEAD);
    do_access(1'b0, 1'b1, 32'd1024, 32'h0);
    check("load_back", bus.readData, 32'hDEADBEEF);

    // Address map; byte lanes of the same word alias
    do_access(1'b1, 1'b0, 32'd1032, 32'h12345678);
    check("sram_w4", 32'(sram[4]), 32'h00005678);
    check("sram_w5", 32'(sram[5]), 32'h00001234);
    do_access(1'b0, 1'b1, 32'd1033, 32'h0);
    do_access(1'b0, 1'b1, 32'd1034, 32'h0);
    do_access(1'b0, 1'b1, 32'd1035, 32'h0);
    check("alias_load", bus.readData, 32'h12345678);

    // Repeated loads, store-wins priority, store invalidating a cached word
    do_access(1'b0, 1'b1, 32'd1024, 32'h0);
    do_access(1'b0, 1'b1, 32'd1024, 32'h0);
    do_access(1'b1, 1'b1, 32'd1028, 32'hA5A55A5A);
    do_access(1'b1, 1'b0, 32'd1024, 32'h0);
    do_access(1'b0, 1'b1, 32'd1024, 32'h0);
    check("load_zero", bus.readData, 32'h0);

    // Reset during the high phase of a store
    wd            = 32'h0BAD_F00D;
    bus.MEM_W_EN  = 1'b1;
    bus.MEM_R_EN  = 1'b0;
    bus.address   = 32'd1040;
    bus.writeData = wd;
    tb_reading    = 1'b0;
    repeat (WAIT + 1) @(negedge clk);
    check("hi_we_n", 32'(SRAM_WE_N), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_we_n", 32'(SRAM_WE_N), 32'd1);
    check("mid_ready_req", 32'(bus.ready), 32'd0);
    check("mid_rdata", bus.readData, 32'h0);
    check("mid_addr", 32'(SRAM_ADDR), 32'h0);
    bus.MEM_W_EN = 1'b0;
    #1;
    check("mid_ready", 32'(bus.ready), 32'd1);
    check_dq_released("mid_dq");
    ref_mem[8] = wd[15:0];
    rd_exp     = '0;
    c_valid    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_access(1'b0, 1'b1, 32'd1040, 32'h0);
    do_access(1'b0, 1'b1, 32'd1032, 32'h0);

    // Random traffic over a small word pool
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 9));
      a  = 32'd1024 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      wd = $urandom | 32'h0001_0001;
      if (op < 2)      do_access(1'b0, 1'b0, a, wd);
      else if (op < 6) do_access(1'b0, 1'b1, a, wd);
      else if (op < 9) do_access(1'b1, 1'b0, a, wd);
      else             do_access(1'b1, 1'b1, a, wd);
    end
    do_access(1'b0, 1'b0, 32'd1024, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
